fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 53 +++++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Groups the requester handshake bus and the FIFO write/status port used by
// fifo_wr_arbiter.
//
// Parameters: DWIDTH (data width), AWIDTH (FIFO address width), NREQ (requesters)
// Optional macro FIFO_WR_ARBITER_TAG_EN: widens fifo_data_o by $clog2(NREQ)
// bits to carry {src_index, data}.
//
// Handshake: a word moves from requester i when req_valid_i[i] && req_ready_o[i]
// are both high at a rising clock edge. A requester holds valid and data stable
// until accepted; ready may depend on valid.
//
// Modports:
//   master - the arbiter: consumes requests and FIFO status, drives ready,
//            the FIFO write port and grant.
//   slave  - the environment: requesters plus the FIFO.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ   = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FIFO_WR_ARBITER_TAG_EN
  localparam int OWIDTH = DWIDTH + GW;
`else
  localparam int OWIDTH = DWIDTH;
`endif

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_last_i;
  logic [NREQ*DWIDTH-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   pkt_mode_i;
  logic                   fifo_wrreq_o;
  logic [OWIDTH-1:0]      fifo_data_o;
  logic                   fifo_full_i;
  logic [AWIDTH-1:0]      fifo_usedw_i;
  logic [GW-1:0]          grant_o;

  modport master (
    input  req_valid_i, req_last_i, req_data_i, pkt_mode_i,
    input  fifo_full_i, fifo_usedw_i,
    output req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o
  );

  modport slave (
    output req_valid_i, req_last_i, req_data_i, pkt_mode_i,
    output fifo_full_i, fifo_usedw_i,
    input  req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of one single-clock FIFO
// among NREQ valid/ready requesters. The FIFO write request and data are
// registered (one cycle from accept to write edge). Acceptance is throttled on
// the FIFO fill level, counting the in-flight registered write, so a write is
// never issued into a full FIFO. Packet mode holds the grant on one requester
// until its last word.
//
// Ports:
//   clk_i    - clock
//   srst_i   - synchronous reset, active-high, highest priority
//   bus      - fifo_wr_arbiter_if.master: req_valid_i/req_last_i/req_data_i/
//              req_ready_o, pkt_mode_i, fifo_wrreq_o/fifo_data_o,
//              fifo_full_i/fifo_usedw_i, grant_o
//   state_o  - FSM state for observation (0 = IDLE, 1 = LOCKED)
//
// Optional macro FIFO_WR_ARBITER_TAG_EN: fifo_data_o = {src_index, data}.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ   = 4
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  fifo_wr_arbiter_if.master      bus,
  output logic                   state_o
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FIFO_WR_ARBITER_TAG_EN
  localparam int OWIDTH = DWIDTH + GW;
`else
  localparam int OWIDTH = DWIDTH;
`endif
  localparam logic [AWIDTH:0]   FULL_FILL = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH+1:0] DEPTH     = (AWIDTH+2)'(2**AWIDTH);

  // LOCKED also records that packet mode was sampled high when the lock began.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_lock_idx;
  logic [GW-1:0]     w_lock_nxt;
  logic              r_wrreq;
  logic [OWIDTH-1:0] r_data;
  logic [GW-1:0]     r_grant;

  logic [AWIDTH:0]   w_fill;
  logic [AWIDTH+1:0] w_sum;
  logic              w_space_ok;
  logic [GW-1:0]     w_sel;
  logic [GW-1:0]     w_cand;
  logic [NREQ-1:0]   w_ready;
  logic              w_xfer;
  logic [DWIDTH-1:0] w_din;
  logic [OWIDTH-1:0] w_wdata;

  // usedw wraps to 0 when full, so full is folded back in as 2**AWIDTH.
  // Concurrent reads are ignored: freed space is seen one cycle later.
  always_comb begin
    w_fill     = bus.fifo_full_i ? FULL_FILL : {1'b0, bus.fifo_usedw_i};
    w_sum      = {1'b0, w_fill} + {{(AWIDTH+1){1'b0}}, r_wrreq};
    w_space_ok = (w_sum < DEPTH);
  end

  // Selection: scan from rr_ptr+NREQ down to rr_ptr+1 so the last hit, the
  // nearest one after rr_ptr, wins. LOCKED pins the selection to lock_idx.
  always_comb begin
    w_sel  = r_rr_ptr;
    w_cand = '0;
    if (r_state == LOCKED) begin
      w_sel = r_lock_idx;
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        w_cand = GW'((int'(r_rr_ptr) + k) % NREQ);
        if (bus.req_valid_i[w_cand]) w_sel = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_space_ok && bus.req_valid_i[w_sel]) w_ready[w_sel] = 1'b1;
    w_xfer = |w_ready;
  end

  always_comb begin
    w_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == GW'(i)) w_din = bus.req_data_i[i*DWIDTH +: DWIDTH];
    end
`ifdef FIFO_WR_ARBITER_TAG_EN
    w_wdata = {w_sel, w_din};
`else
    w_wdata = w_din;
`endif
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_idx;
    case (r_state)
      IDLE: begin
        if (w_xfer && bus.pkt_mode_i && !bus.req_last_i[w_sel]) begin
          w_state_nxt = LOCKED;
          w_lock_nxt  = w_sel;
        end
      end
      LOCKED: begin
        if (w_xfer && bus.req_last_i[w_sel]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= GW'(NREQ - 1);
      r_wrreq    <= 1'b0;
      r_data     <= '0;
      r_grant    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_nxt;
      r_wrreq    <= w_xfer;
      if (w_xfer) begin
        r_data   <= w_wdata;
        r_grant  <= w_sel;
        r_rr_ptr <= w_sel;
      end
    end
  end

  assign bus.req_ready_o  = w_ready;
  assign bus.fifo_wrreq_o = r_wrreq;
  assign bus.fifo_data_o  = r_data;
  assign bus.grant_o      = r_grant;
  assign state_o          = (r_state == LOCKED);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Bench for fifo_wr_arbiter with NREQ=4, DWIDTH=8, AWIDTH=4. A behavioural
// FIFO (depth 16, usedw wrapping to 0 when full) sits on the write port.
// Every accepted word is pushed to exp_q and popped when the FIFO write
// appears one cycle later.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 4;
  localparam int NREQ   = 4;
  localparam int GW     = 2;
  localparam int DEPTH  = 16;
`ifdef FIFO_WR_ARBITER_TAG_EN
  localparam int OWIDTH = DWIDTH + GW;
`else
  localparam int OWIDTH = DWIDTH;
`endif

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    logic            pkt;
    logic            rst;
    logic [NREQ-1:0] exp_ready;
    logic            exp_wrreq;
    logic [GW-1:0]   exp_grant;
    logic            exp_state;
  } vec_t;

  logic clk = 1'b0;
  logic srst;
  logic state;
  logic rd_en;
  logic [AWIDTH:0]   model_cnt;
  logic [OWIDTH-1:0] fifo_mem[$];
  logic [OWIDTH-1:0] exp_q[$];
  logic [DWIDTH-1:0] data [NREQ];
  logic [NREQ-1:0]   acc_mask = '0;
  logic              chk_rd = 1'b0;
  logic [DWIDTH-1:0] rd_expect;
  int compared = 0, mismatched = 0, acc_cnt = 0, ovf = 0, rd_cnt = 0;

  vec_t t1 [8];
  vec_t t3 [8];
  vec_t t4 [4];

  fifo_wr_arbiter_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NREQ(NREQ)) dut (
    .clk_i   (clk),
    .srst_i  (srst),
    .bus     (bus.master),
    .state_o (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) bus.req_data_i[i*DWIDTH +: DWIDTH] = data[i];
  end

  assign bus.fifo_full_i  = (model_cnt == 5'd16);
  assign bus.fifo_usedw_i = model_cnt[AWIDTH-1:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [OWIDTH-1:0] m_word;
  always @(posedge clk) begin
    if (srst) begin
      fifo_mem.delete();
      model_cnt <= '0;
    end else begin
      if (rd_en && fifo_mem.size() > 0) begin
        m_word = fifo_mem.pop_front();
        if (chk_rd) begin
          check("fifo_q_order", 32'(m_word[DWIDTH-1:0]), 32'(rd_expect));
          rd_expect = rd_expect + 1'b1;
          rd_cnt++;
        end
      end
      if (bus.fifo_wrreq_o) begin
        if (fifo_mem.size() >= DEPTH) ovf++;
        else fifo_mem.push_back(bus.fifo_data_o);
      end
      model_cnt <= (AWIDTH+1)'(fifo_mem.size());
    end
  end

  // ---------------- scoreboard ----------------
  logic [OWIDTH-1:0] sb_exp;
  always @(negedge clk) begin
    if (bus.fifo_wrreq_o) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_unexpected_write: got 0x%0h, expected no write", bus.fifo_data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_fifo_data", 32'(bus.fifo_data_o), 32'(sb_exp));
      end
    end
    acc_mask = bus.req_ready_o & bus.req_valid_i;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) begin
        acc_cnt++;
`ifdef FIFO_WR_ARBITER_TAG_EN
        exp_q.push_back({GW'(i), data[i]});
`else
        exp_q.push_back(data[i]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit past the next rising edge; requesters whose word
  // was accepted present a fresh word.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc_mask[i]) data[i] = data[i] + 1'b1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.pkt_mode_i  = 1'b0;
    tick();
    tick();
    srst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bus.req_valid_i = v.valid;
    bus.req_last_i  = v.last;
    bus.pkt_mode_i  = v.pkt;
    srst            = v.rst;
    @(negedge clk);
    check({name, "_ready"}, 32'(bus.req_ready_o), 32'(v.exp_ready));
    check({name, "_wrreq"}, 32'(bus.fifo_wrreq_o), 32'(v.exp_wrreq));
    check({name, "_grant"}, 32'(bus.grant_o), 32'(v.exp_grant));
    check({name, "_state"}, 32'(state), 32'(v.exp_state));
    tick();
  endtask

  int start_acc;

  initial begin
    // valid, last, pkt, rst, exp_ready, exp_wrreq, exp_grant, exp_state
    t1 = '{
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0}
    };
    // req 0 single word moves rr_ptr to 0; req 1 then sends a 3-word packet
    // (with one idle cycle inside) while 0 and 3 wait; then 3, then 0.
    t3 = '{
      '{4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b1011, 4'b1001, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0},
      '{4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1},
      '{4'b1011, 4'b1001, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1},
      '{4'b1011, 4'b1011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1},
      '{4'b1001, 4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b0},
      '{4'b0001, 4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0}
    };
    // req 2 locks, reset mid-packet, then requester 0 wins with all valid.
    t4 = '{
      '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1},
      '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0}
    };
    for (int i = 0; i < NREQ; i++) data[i] = DWIDTH'(8'h10 * i);
    rd_en = 1'b1;

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_wrreq", 32'(bus.fifo_wrreq_o), 32'd0);
    check("rst_data", 32'(bus.fifo_data_o), 32'd0);
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    tick();

    // ---- rotation with all requesters valid ----
    for (int r = 0; r < 8; r++) run_vec(t1[r], $sformatf("rot%0d", r));

    // ---- fill to full, no reads ----
    do_reset();
    rd_en = 1'b0;
    start_acc = acc_cnt;
    bus.req_valid_i = 4'b0100;
    repeat (24) tick();
    check("fill_accepts", 32'(acc_cnt - start_acc), 32'd16);
    check("fill_full", 32'(bus.fifo_full_i), 32'd1);
    check("fill_usedw_wrap", 32'(bus.fifo_usedw_i), 32'd0);
    check("fill_ready_low", 32'(bus.req_ready_o), 32'd0);
    rd_en = 1'b1;
    @(negedge clk);
    check("full_rd_no_accept", 32'(bus.req_ready_o), 32'd0);
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    check("after_rd_accept", 32'(bus.req_ready_o), 32'b0100);
    repeat (6) tick();
    check("after_rd_total", 32'(acc_cnt - start_acc), 32'd17);
    bus.req_valid_i = '0;
    rd_en = 1'b1;
    tick();

    // ---- packet mode ----
    do_reset();
    for (int r = 0; r < 8; r++) run_vec(t3[r], $sformatf("pkt%0d", r));

    // ---- reset mid-packet ----
    do_reset();
    for (int r = 0; r < 4; r++) run_vec(t4[r], $sformatf("srst%0d", r));

    // ---- single requester, random valid and random reads ----
    do_reset();
    start_acc = acc_cnt;
    rd_cnt = 0;
    rd_expect = data[1];
    chk_rd = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (acc_mask[1] || !bus.req_valid_i[1])
        bus.req_valid_i[1] = 1'($urandom_range(0, 1));
      rd_en = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.req_valid_i = '0;
    rd_en = 1'b1;
    repeat (DEPTH + 4) tick();
    check("stream_count", 32'(rd_cnt), 32'(acc_cnt - start_acc));
    chk_rd = 1'b0;

    // ---- tag build / data-only build ----
    do_reset();
    data[3] = 8'hA5;
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    check("tag_ready", 32'(bus.req_ready_o), 32'b1000);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk);
    check("tag_wrreq", 32'(bus.fifo_wrreq_o), 32'd1);
    check("tag_grant", 32'(bus.grant_o), 32'd3);
`ifdef FIFO_WR_ARBITER_TAG_EN
    check("tag_data", 32'(bus.fifo_data_o), 32'h3A5);
`else
    check("tag_data", 32'(bus.fifo_data_o), 32'hA5);
`endif
    tick();
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("no_overflow", 32'(ovf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
